// File: rtl/alu_rf_unit_pkg.sv
// Shared constants for the ALU/register-file unit: default word width and
// the alucontrol operation encodings.
package alu_rf_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int NREGS_DEFAULT = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_rf_unit_rf_core.sv
// Two-read, one-write register file with combinational reads, no write
// bypass, hard-wired zero at address 0 and asynchronous active-low clear.
module rf_core
  import alu_rf_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Entry 0 is never written; it stays at its cleared value.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            regs[gi] <= '0;
          end
        end
      end else begin : g_word
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            regs[gi] <= '0;
          end else if (we3 && (wa3 == AW'(gi))) begin
            regs[gi] <= wd3;
          end
        end
      end
    end
  endgenerate

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_rf_unit.sv
// Register file plus combinational ALU, B-operand mux and pc+4 incrementer.
module alu_rf_unit
  import alu_rf_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             alusrc,
  input  logic [WIDTH-1:0] imm,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4
);

  logic [WIDTH-1:0] src_b;
  logic             slt;

  rf_core #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf_core (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  assign src_b = alusrc ? imm : rd2;
  assign slt   = ($signed(rd1) < $signed(src_b));

  always_comb begin
    aluout = '0;
    case (alucontrol)
      ALU_AND:  aluout = rd1 & src_b;
      ALU_OR:   aluout = rd1 | src_b;
      ALU_ADD:  aluout = rd1 + src_b;
      ALU_SUB:  aluout = rd1 - src_b;
      ALU_SLT:  aluout = {{(WIDTH-1){1'b0}}, slt};
      ALU_ANDN: aluout = rd1 & ~src_b;
      ALU_ORN:  aluout = rd1 | ~src_b;
      ALU_ZERO: aluout = '0;
      default:  aluout = '0;
    endcase
  end

  assign zero    = (aluout == '0);
  assign pcplus4 = pc + WIDTH'(4);

endmodule

// File: tb/tb_alu_rf_unit.sv
// Self-checking bench for alu_rf_unit: directed scenarios plus randomized
// traffic compared against an array-based register model and arithmetic ALU model.
module tb_alu_rf_unit;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] wd3, rd1, rd2;
  logic        alusrc;
  logic [31:0] imm;
  logic [2:0]  alucontrol;
  logic [31:0] aluout;
  logic        zero;
  logic [31:0] pc, pcplus4;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  alu_rf_unit dut (
    .clk        (clk),
    .reset      (reset),
    .we3        (we3),
    .ra1        (ra1),
    .ra2        (ra2),
    .wa3        (wa3),
    .wd3        (wd3),
    .rd1        (rd1),
    .rd2        (rd2),
    .alusrc     (alusrc),
    .imm        (imm),
    .alucontrol (alucontrol),
    .aluout     (aluout),
    .zero       (zero),
    .pc         (pc),
    .pcplus4    (pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we3 = 1'b1; wa3 = addr; wd3 = data;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    if (addr != 5'd0) model[addr] = data;
    $display("write r%0d <= %h", addr, data);
  endtask

  task automatic test_reset();
    reset = 1'b0; we3 = 1'b0; ra1 = 5'd5; ra2 = 5'd31; wa3 = 5'd0; wd3 = 32'd0;
    alusrc = 1'b0; imm = 32'd0; alucontrol = 3'b010; pc = 32'd0;
    clear_model();
    #3;
    checks++;
    if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want %h", rd1, 32'd0); end
    checks++;
    if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want %h", rd2, 32'd0); end
    checks++;
    if (aluout !== 32'd0) begin errors++; $display("FAIL reset_aluout got %h want %h", aluout, 32'd0); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    @(negedge clk);
    reset = 1'b1;
    $display("reset: rd1=%h rd2=%h aluout=%h zero=%b", rd1, rd2, aluout, zero);
  endtask

  task automatic test_write_read();
    write_reg(5'd8, 32'h12345678);
    ra1 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'h12345678) begin errors++; $display("FAIL wr_r8 got %h want %h", rd1, 32'h12345678); end
    write_reg(5'd0, 32'hFFFFFFFF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin errors++; $display("FAIL r0_rd1 got %h want %h", rd1, 32'd0); end
    checks++;
    if (rd2 !== 32'd0) begin errors++; $display("FAIL r0_rd2 got %h want %h", rd2, 32'd0); end
  endtask

  task automatic test_alu_directed();
    logic [2:0]  ops  [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101, 3'b011};
    logic [31:0] want [8] = '{32'd5, 32'd9, 32'd6, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd7, 32'd0};
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'hFFFFFFFE);
    ra1 = 5'd1; ra2 = 5'd2; alusrc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alucontrol = ops[i];
      #1;
      checks++;
      if (aluout !== want[i]) begin
        errors++;
        $display("FAIL alu_op%b got %h want %h", ops[i], aluout, want[i]);
      end
      $display("alu op=%b a=r1 b=r2 -> %h", ops[i], aluout);
    end
    ra1 = 5'd2; ra2 = 5'd1; alucontrol = 3'b111;
    #1;
    checks++;
    if (aluout !== 32'd1) begin errors++; $display("FAIL slt_neg got %h want %h", aluout, 32'd1); end
  endtask

  task automatic test_zero_flag();
    write_reg(5'd3, 32'h10);
    ra1 = 5'd3; alusrc = 1'b1; imm = 32'h10; alucontrol = 3'b110;
    #1;
    checks++;
    if (aluout !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL zero_eq got %h/%b want 00000000/1", aluout, zero);
    end
    imm = 32'h11;
    #1;
    checks++;
    if (aluout !== 32'hFFFFFFFF || zero !== 1'b0) begin
      errors++; $display("FAIL zero_ne got %h/%b want ffffffff/0", aluout, zero);
    end
    alusrc = 1'b0;
  endtask

  task automatic test_pc();
    pc = 32'h00400000;
    #1;
    checks++;
    if (pcplus4 !== 32'h00400004) begin errors++; $display("FAIL pc_inc got %h want %h", pcplus4, 32'h00400004); end
    pc = 32'hFFFFFFFC;
    #1;
    checks++;
    if (pcplus4 !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h want %h", pcplus4, 32'd0); end
    $display("pc wrap: pcplus4=%h", pcplus4);
  endtask

  task automatic test_back_to_back();
    // Same-cycle write and read of one register: old value before the edge.
    logic [31:0] newv;
    for (int k = 0; k < 4; k++) begin
      logic [4:0] a;
      a = 5'($urandom_range(1, 31));
      newv = $urandom;
      @(negedge clk);
      we3 = 1'b1; wa3 = a; wd3 = newv; ra1 = a; ra2 = a;
      #1;
      checks++;
      if (rd1 !== model[a]) begin errors++; $display("FAIL rdw_old got %h want %h", rd1, model[a]); end
      @(posedge clk);
      #1;
      we3 = 1'b0;
      model[a] = newv;
      checks++;
      if (rd2 !== model[a]) begin errors++; $display("FAIL rdw_new got %h want %h", rd2, model[a]); end
      $display("rdw r%0d new=%h", a, newv);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      we3 = 1'($urandom); wa3 = 5'($urandom); wd3 = $urandom;
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      alusrc = 1'($urandom); imm = (n % 4 == 0) ? model[ra1] : $urandom;
      alucontrol = 3'($urandom); pc = $urandom;
      #1;
      a = model[ra1];
      b = alusrc ? imm : model[ra2];
      exp = alu_model(alucontrol, a, b);
      checks++;
      if (rd1 !== a || rd2 !== model[ra2]) begin
        errors++; $display("FAIL rand_rd got %h/%h want %h/%h", rd1, rd2, a, model[ra2]);
      end
      checks++;
      if (aluout !== exp || zero !== (exp == 32'd0)) begin
        errors++; $display("FAIL rand_alu op=%b got %h/%b want %h/%b", alucontrol, aluout, zero, exp, exp == 32'd0);
      end
      checks++;
      if (pcplus4 !== pc + 32'd4) begin errors++; $display("FAIL rand_pc got %h want %h", pcplus4, pc + 32'd4); end
      $display("rand %0d op=%b a=%h b=%h out=%h", n, alucontrol, a, b, aluout);
      @(posedge clk);
      #1;
      if (we3 && wa3 != 5'd0) model[wa3] = wd3;
    end
    we3 = 1'b0;
  endtask

  task automatic test_async_reset();
    write_reg(5'd9, 32'hA5A5A5A5);
    ra1 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL r9_pre got %h want %h", rd1, 32'hA5A5A5A5); end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    checks++;
    if (rd1 !== 32'd0) begin errors++; $display("FAIL async_clr got %h want %h", rd1, 32'd0); end
    // Writes are blocked while reset is held, even across a clock edge.
    we3 = 1'b1; wa3 = 5'd4; wd3 = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    @(negedge clk);
    we3 = 1'b0;
    reset = 1'b1;
    ra1 = 5'd4; ra2 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin errors++; $display("FAIL rst_blk got %h want %h", rd1, 32'd0); end
    checks++;
    if (rd2 !== 32'd0) begin errors++; $display("FAIL rst_r8 got %h want %h", rd2, 32'd0); end
    $display("async reset: r9 cleared, r4=%h", rd1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alu_directed();
    test_zero_flag();
    test_pc();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rf_unit.md
ALU_RF_UNIT -- requirements
Module: alu_rf_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath word width in bits.
REQ-002 Parameter NREGS, default 32: register count; address width is log2(NREGS) = 5.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous and active-low.
REQ-005 Port we3, input, 1: register write enable.
REQ-006 Port ra1, input, 5: read address of port 1 (rd1).
REQ-007 Port ra2, input, 5: read address of port 2 (rd2).
REQ-008 Port wa3, input, 5: write address.
REQ-009 Port wd3, input, WIDTH: write data.
REQ-010 Port rd1, output, WIDTH: read data of port 1.
REQ-011 Port rd2, output, WIDTH: read data of port 2.
REQ-012 Port alusrc, input, 1: selects the ALU B operand; 0 = rd2, 1 = imm.
REQ-013 Port imm, input, WIDTH: immediate operand, already extended by the caller.
REQ-014 Port alucontrol, input, 3: ALU operation code.
REQ-015 Port aluout, output, WIDTH: ALU result.
REQ-016 Port zero, output, 1: high when aluout equals 0.
REQ-017 Port pc, input, WIDTH: current program counter.
REQ-018 Port pcplus4, output, WIDTH: pc + 4.

Function
REQ-019 Reads SHALL be combinational (zero latency) on both ports.
- rd1 = R[ra1]; rd2 = R[ra2].
- Address 0 SHALL always read 0.
REQ-020 When we3 = 1 and wa3 != 0, wd3 SHALL be written into R[wa3] on the rising edge of clk.
- Writes to address 0 SHALL be discarded.
REQ-021 Read-during-write SHALL have no bypass: a read of the address being written returns the old value until after the clock edge.
REQ-022 ALU operand A SHALL be rd1; operand B SHALL be the alusrc mux output.
REQ-023 alucontrol decode (all arithmetic wraps modulo 2^WIDTH; overflow ignored):
- 000 = A AND B
- 001 = A OR B
- 010 = A + B
- 110 = A - B
- 111 = SLT signed: 1 if A < B as two's complement, else 0
- 100 = A AND NOT B
- 101 = A OR NOT B
- 011 = 0
REQ-024 aluout and zero SHALL be purely combinational, with no registers in the ALU path.
REQ-025 pcplus4 SHALL equal pc + 4, wrapping modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-026 Simultaneous write to and reads of the same register in one cycle SHALL follow REQ-021.

Reset
REQ-027 While reset = 0, all registers SHALL clear to 0 asynchronously, independent of clk.
REQ-028 While reset = 0, writes SHALL be blocked, including when we3 = 1.
REQ-029 The combinational outputs (aluout, zero, pcplus4) SHALL have no reset state.
- With all registers cleared and alusrc = 0, alucontrol = 010, aluout SHALL read 0 and zero SHALL read 1.
REQ-030 Reset asserted mid-operation SHALL discard any pending write in that cycle.

Structure
REQ-031 A shared package SHALL hold the alucontrol encodings as named constants and the WIDTH default.
REQ-032 The register file SHALL be one sub-module named rf_core.
- The ALU, operand mux and pc+4 incrementer SHALL stay inline in alu_rf_unit.

Verification
REQ-033 Reset then read: after reset, ra1 = 5, ra2 = 31 -> rd1 = 0, rd2 = 0.
REQ-034 Write then read: write 0x12345678 to r8; next cycle ra1 = 8 -> rd1 = 0x12345678.
- Write 0xFFFFFFFF to r0 -> r0 still reads 0.
REQ-035 ALU checks with r1 = 7, r2 = 0xFFFFFFFE (-2), alusrc = 0:
- ADD = 5
- SUB = 9
- AND = 6
- OR = 0xFFFFFFFF
- SLT (A = r1, B = r2) = 0
- SLT (A = r2, B = r1) = 1
REQ-036 Zero flag: r3 = 0x10, alusrc = 1, imm = 0x10, alucontrol = 110 -> aluout = 0, zero = 1.
- Same setup with imm = 0x11 -> aluout = 0xFFFFFFFF, zero = 0.
REQ-037 PC adder: pc = 0x00400000 -> pcplus4 = 0x00400004; pc = 0xFFFFFFFC -> pcplus4 = 0.
REQ-038 Asynchronous reset: write 0xA5A5A5A5 to r9, then pulse reset low between clock edges -> rd1 (ra1 = 9) reads 0 immediately, before the next clk edge.
